// File: rtl/serial_adder_pkg.sv
// Shared types for the bit-serial adder.
// State encoding; the spare code behaves as IDLE.
package serial_adder_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2,
      ST_RSVD = 2'd3
   } state_e;

endpackage

// File: rtl/full_adder.sv
// 1-bit full adder cell.
// Used as the single bit-slice of the serial adder.
module full_adder (
   input  logic in1,
   input  logic in2,
   input  logic carryin,
   output logic sum,
   output logic carry
);

   logic p;

   assign p     = in1 ^ in2;
   assign sum   = p ^ carryin;
   assign carry = (in1 & in2) | (carryin & p);

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first.
// One full_adder slice with a registered carry.
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_e           state_q;
   logic [WIDTH-1:0] sh_a_q;
   logic [WIDTH-1:0] sh_b_q;
   logic [WIDTH-2:0] sh_s_q;
   logic [WIDTH-1:0] sh_s_d;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             fa_s;
   logic             fa_c;

   full_adder u_fa (
      .in1     (sh_a_q[0]),
      .in2     (sh_b_q[0]),
      .carryin (carry_q),
      .sum     (fa_s),
      .carry   (fa_c)
   );

   // New sum bit enters at the MSB; after WIDTH bits it is LSB-aligned.
   assign sh_s_d = {fa_s, sh_s_q};

   // FSM with operand/sum shifters, carry, counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         sh_a_q  <= '0;
         sh_b_q  <= '0;
         sh_s_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            ST_RUN: begin
               sh_a_q  <= sh_a_q >> 1;
               sh_b_q  <= sh_b_q >> 1;
               sh_s_q  <= sh_s_d[WIDTH-1:1];
               carry_q <= fa_c;
               if (cnt_q == CNT_LAST) begin
                  sum_q   <= sh_s_d;
                  cout_q  <= fa_c;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               if (start) begin
                  sh_a_q  <= a;
                  sh_b_q  <= b;
                  carry_q <= cin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_RUN;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder at WIDTH 8 and 4.
// Stimulus pushes expected results; monitors pop on done.
module tb_serial_adder;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       cin8 = 1'b0;
   logic       busy8, done8, cout8;
   logic [7:0] sum8;

   logic       start4 = 1'b0;
   logic [3:0] a4 = '0;
   logic [3:0] b4 = '0;
   logic       cin4 = 1'b0;
   logic       busy4, done4, cout4;
   logic [3:0] sum4;

   logic [8:0] q8[$];
   logic [8:0] q4[$];
   logic [8:0] last8 = '0;
   logic [8:0] last4 = '0;
   logic [8:0] pend8 = '0;
   logic [8:0] pend4 = '0;

   int vec = 0;
   int bad = 0;

   always #5 clk = ~clk;

   serial_adder #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a     (a8),
      .b     (b8),
      .cin   (cin8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .cout  (cout8)
   );

   serial_adder #(.WIDTH(4)) dut4 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start4),
      .a     (a4),
      .b     (b4),
      .cin   (cin4),
      .busy  (busy4),
      .done  (done4),
      .sum   (sum4),
      .cout  (cout4)
   );

   task automatic chk(input string nm,
                      input logic [8:0] act,
                      input logic [8:0] exp);
      vec++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Monitor for the 8-bit instance.
   always @(negedge clk) begin
      if (rst_n && done8) begin
         if (q8.size() == 0) begin
            vec++;
            bad++;
            $display("FAIL done8_unexpected: got %h want none",
                     {cout8, sum8});
         end else begin
            chk("res8", {cout8, sum8}, q8.pop_front());
         end
      end
   end

   // Monitor for the 4-bit instance.
   always @(negedge clk) begin
      if (rst_n && done4) begin
         if (q4.size() == 0) begin
            vec++;
            bad++;
            $display("FAIL done4_unexpected: got %h want none",
                     {cout4, sum4});
         end else begin
            chk("res4", {4'b0, cout4, sum4}, q4.pop_front());
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic issue(input bit w4,
                        input logic [7:0] ta,
                        input logic [7:0] tb_,
                        input logic tc,
                        input logic [8:0] ev,
                        input bit push);
      if (w4) begin
         start4 = 1'b1;
         a4 = ta[3:0];
         b4 = tb_[3:0];
         cin4 = tc;
         if (push) begin
            q4.push_back(ev);
            pend4 = ev;
         end
      end else begin
         start8 = 1'b1;
         a8 = ta;
         b8 = tb_;
         cin8 = tc;
         if (push) begin
            q8.push_back(ev);
            pend8 = ev;
         end
      end
      @(negedge clk);
      start8 = 1'b0;
      start4 = 1'b0;
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      cin8 = 1'($urandom);
      a4 = 4'($urandom);
      b4 = 4'($urandom);
      cin4 = 1'($urandom);
   endtask

   // Waits for done, checking busy, held result and latency.
   task automatic wait_done(input bit w4, input int e0);
      int e;
      int w;
      logic [8:0] held;
      e = e0;
      w = w4 ? 4 : 8;
      held = w4 ? last4 : last8;
      while (!(w4 ? done4 : done8) && e < 4 * w) begin
         chk(w4 ? "busy4" : "busy8",
             9'(w4 ? busy4 : busy8), 9'd1);
         chk(w4 ? "hold4" : "hold8",
             w4 ? {4'b0, cout4, sum4} : {cout8, sum8}, held);
         @(negedge clk);
         e++;
      end
      chk(w4 ? "lat4" : "lat8", 9'(e), 9'(w));
      if (w4) last4 = pend4;
      else last8 = pend8;
   endtask

   task automatic idle_chk(input bit w4);
      @(negedge clk);
      chk(w4 ? "idle_busy4" : "idle_busy8",
          9'(w4 ? busy4 : busy8), 9'd0);
      chk(w4 ? "idle_done4" : "idle_done8",
          9'(w4 ? done4 : done8), 9'd0);
   endtask

   initial begin
      logic [3:0] ra;
      logic [3:0] rb;
      logic       rc;

      #1 rst_n = 1'b0;
      #2;
      chk("rst_busy8", 9'(busy8), 9'd0);
      chk("rst_done8", 9'(done8), 9'd0);
      chk("rst_res8", {cout8, sum8}, 9'h000);
      chk("rst_res4", {4'b0, cout4, sum4}, 9'h000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Zero operands.
      issue(0, 8'h00, 8'h00, 1'b0, 9'h000, 1);
      wait_done(0, 0);
      idle_chk(0);

      // Carry propagation.
      @(negedge clk);
      issue(0, 8'hFF, 8'h01, 1'b0, 9'h100, 1);
      wait_done(0, 0);
      idle_chk(0);
      issue(0, 8'hA5, 8'h5A, 1'b1, 9'h100, 1);
      wait_done(0, 0);
      idle_chk(0);

      // Start pulsed mid-RUN must be ignored.
      issue(0, 8'h3C, 8'h42, 1'b0, 9'h07E, 1);
      start8 = 1'b1;
      a8 = 8'hFF;
      b8 = 8'hFF;
      cin8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      wait_done(0, 1);
      idle_chk(0);
      idle_chk(0);

      // Back-to-back: restart from DONE without IDLE.
      issue(0, 8'h10, 8'h20, 1'b0, 9'h030, 1);
      wait_done(0, 0);
      issue(0, 8'h01, 8'h01, 1'b0, 9'h002, 1);
      wait_done(0, 0);
      idle_chk(0);

      // Reset three cycles into an operation.
      issue(0, 8'hC3, 8'h3C, 1'b0, 9'h0FF, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_busy8", 9'(busy8), 9'd0);
      chk("mid_rst_done8", 9'(done8), 9'd0);
      chk("mid_rst_res8", {cout8, sum8}, 9'h000);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      last8 = '0;
      last4 = '0;
      idle_chk(0);
      issue(0, 8'hC3, 8'h3C, 1'b1, 9'h100, 1);
      wait_done(0, 0);
      idle_chk(0);

      // Narrow instance, all ones.
      issue(1, 8'h0F, 8'h0F, 1'b1, 9'h01F, 1);
      wait_done(1, 0);
      idle_chk(1);

      // Random operations on the narrow instance.
      for (int i = 0; i < 1000; i++) begin
         ra = 4'($urandom);
         rb = 4'($urandom);
         rc = 1'($urandom);
         issue(1, {4'h0, ra}, {4'h0, rb}, rc,
               9'(ra) + 9'(rb) + 9'(rc), 1);
         wait_done(1, 0);
         if (i % 3 == 0) idle_chk(1);
      end
      idle_chk(1);

      chk("q8_drained", 9'(q8.size()), 9'd0);
      chk("q4_drained", 9'(q4.size()), 9'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vec, bad);
      $finish;
   end

endmodule
